// File: rtl/data_memory_mc.sv
// -----------------------------------------------------------------------------
// data_memory_mc
//
// Multi-cycle data memory with a valid/ready request channel. A request is
// accepted, held for LATENCY cycles, then committed (store written / load
// sampled) on the edge that raises the one-cycle resp_valid pulse. Supports
// byte/halfword/word accesses, sign/zero-extended loads and lane-masked stores.
// Misaligned, illegal-size and out-of-range accesses respond with resp_error
// and never touch the array.
//
// Parameters:
//   MEM_DEPTH     number of 32-bit words in the array
//   LATENCY       cycles from acceptance to response, 1..255
//
// Ports:
//   clk           clock, rising edge
//   reset         asynchronous active-low reset
//   req_valid     request present
//   req_ready     request can be accepted this cycle
//   req_addr      byte address
//   req_write     1 = store, 0 = load
//   req_size      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  zero-extend sub-word loads when 1
//   req_wdata     right-aligned store data
//   resp_valid    one-cycle completion pulse
//   resp_rdata    extended load data, 0 for stores and errors
//   resp_error    access was rejected
// -----------------------------------------------------------------------------
module data_memory_mc #(
    parameter int unsigned MEM_DEPTH = 16384,
    parameter int unsigned LATENCY   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int unsigned AW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [7:0]  LAT_M1 = 8'(LATENCY - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Array is intentionally outside the reset domain: contents survive reset.
    logic [31:0] r_mem [MEM_DEPTH];

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic [31:0] r_addr;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_error;

    logic [1:0]  w_state_nx;
    logic [7:0]  w_cnt_nx;
    logic        w_accept;
    logic        w_commit;
    logic        w_from_reg;

    logic [31:0] w_c_addr;
    logic        w_c_write;
    logic [1:0]  w_c_size;
    logic        w_c_unsigned;
    logic [31:0] w_c_wdata;

    logic          w_misalign;
    logic          w_oob;
    logic          w_err;
    logic [AW-1:0] w_idx;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata_al;
    logic [31:0]   w_rword;
    logic [31:0]   w_shifted;
    logic [31:0]   w_load;

    assign req_ready  = (r_state != S_BUSY);
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign resp_error = r_error;

    // reset gates acceptance so nothing can commit while the block is held.
    assign w_accept = reset && req_valid && req_ready;

    // With LATENCY==1 the accept edge is also the commit edge, so the live
    // request fields are used; otherwise the latched copy from BUSY.
    assign w_commit   = (reset && (r_state == S_BUSY) && (r_cnt == 8'd1)) ||
                        (w_accept && (LATENCY == 1));
    assign w_from_reg = (r_state == S_BUSY);

    assign w_c_addr     = w_from_reg ? r_addr     : req_addr;
    assign w_c_write    = w_from_reg ? r_write    : req_write;
    assign w_c_size     = w_from_reg ? r_size     : req_size;
    assign w_c_unsigned = w_from_reg ? r_unsigned : req_unsigned;
    assign w_c_wdata    = w_from_reg ? r_wdata    : req_wdata;

    // ------------------------------------------------------------------
    // Access decode for the committing request
    // ------------------------------------------------------------------
    always_comb begin
        w_misalign = 1'b0;
        unique case (w_c_size)
            SZ_BYTE: w_misalign = 1'b0;
            SZ_HALF: w_misalign = w_c_addr[0];
            SZ_WORD: w_misalign = (w_c_addr[1:0] != 2'b00);
            default: w_misalign = 1'b1;  // size 11 is illegal
        endcase
    end

    assign w_oob = (w_c_addr[31:2] >= 30'(MEM_DEPTH));
    assign w_err = w_misalign || w_oob;
    assign w_idx = w_c_addr[AW+1:2];

    always_comb begin
        w_be       = 4'b0000;
        w_wdata_al = w_c_wdata;
        unique case (w_c_size)
            SZ_BYTE: begin
                w_be       = 4'b0001 << w_c_addr[1:0];
                w_wdata_al = {4{w_c_wdata[7:0]}};
            end
            SZ_HALF: begin
                w_be       = w_c_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_al = {2{w_c_wdata[15:0]}};
            end
            SZ_WORD: begin
                w_be       = 4'b1111;
                w_wdata_al = w_c_wdata;
            end
            default: begin
                w_be       = 4'b0000;
                w_wdata_al = w_c_wdata;
            end
        endcase
    end

    // Load path: selected lane shifted down to bit 0 then extended.
    assign w_rword   = r_mem[w_idx];
    assign w_shifted = w_rword >> {w_c_addr[1:0], 3'b000};

    always_comb begin
        w_load = w_rword;
        unique case (w_c_size)
            SZ_BYTE: w_load = w_c_unsigned ? {24'd0, w_shifted[7:0]}
                                           : {{24{w_shifted[7]}}, w_shifted[7:0]};
            SZ_HALF: w_load = w_c_unsigned ? {16'd0, w_shifted[15:0]}
                                           : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default: w_load = w_rword;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        case (r_state)
            S_IDLE, S_RESP: begin
                if (w_accept) begin
                    w_cnt_nx   = LAT_M1;
                    w_state_nx = (LATENCY == 1) ? S_RESP : S_BUSY;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_BUSY: begin
                w_cnt_nx = r_cnt - 8'd1;
                if (r_cnt == 8'd1) begin
                    w_state_nx = S_RESP;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_addr     <= 32'd0;
            r_write    <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
            r_error    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            if (w_accept) begin
                r_addr     <= req_addr;
                r_write    <= req_write;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_wdata    <= req_wdata;
            end
            if (w_commit) begin
                r_error <= w_err;
                r_rdata <= (w_c_write || w_err) ? 32'd0 : w_load;
            end
        end
    end

    // Store commit: only selected lanes are updated.
    always_ff @(posedge clk) begin
        if (w_commit && w_c_write && !w_err) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[w_idx][8*k +: 8] <= w_wdata_al[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_mc.sv
module tb_data_memory_mc;

    localparam int DEPTH = 1024;

    logic        clk;
    logic        reset;
    logic [31:0] req_addr;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;

    // index 0: LATENCY 4, index 1: LATENCY 1, index 2: LATENCY 3
    logic        vld [3];
    logic        rdy [3];
    logic        rv  [3];
    logic        re  [3];
    logic [31:0] rd  [3];

    int checks;
    int errors;

    // Reference model: byte-addressed image of each instance's array.
    logic [7:0] mdl [3][4*DEPTH];

    data_memory_mc #(.MEM_DEPTH(DEPTH), .LATENCY(4)) u_dut4 (
        .clk(clk), .reset(reset), .req_valid(vld[0]), .req_ready(rdy[0]),
        .req_addr(req_addr), .req_write(req_write), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .resp_valid(rv[0]), .resp_rdata(rd[0]), .resp_error(re[0])
    );

    data_memory_mc #(.MEM_DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(vld[1]), .req_ready(rdy[1]),
        .req_addr(req_addr), .req_write(req_write), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .resp_valid(rv[1]), .resp_rdata(rd[1]), .resp_error(re[1])
    );

    data_memory_mc #(.MEM_DEPTH(DEPTH), .LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .req_valid(vld[2]), .req_ready(rdy[2]),
        .req_addr(req_addr), .req_write(req_write), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .resp_valid(rv[2]), .resp_rdata(rd[2]), .resp_error(re[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int d);
        return (d == 0) ? 4 : (d == 1) ? 1 : 3;
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic exp_err(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'b11) return 1'b1;
        if ((a % nbytes(sz)) != 0) return 1'b1;
        if ((a >> 2) >= 32'(DEPTH)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_rdata(input int d, input logic [31:0] a, input logic w,
                                              input logic [1:0] sz, input logic u);
        logic [31:0] val;
        int nb;
        if (w || exp_err(a, sz)) return 32'd0;
        nb  = nbytes(sz);
        val = 32'd0;
        for (int i = 0; i < nb; i++) val = val + (32'(mdl[d][int'(a) + i]) << (8 * i));
        if (nb < 4 && !u && ((val >> (8 * nb - 1)) & 32'd1) == 32'd1)
            val = val - (32'd1 << (8 * nb));
        return val;
    endfunction

    task automatic model_store(input int d, input logic [31:0] a, input logic [1:0] sz,
                               input logic [31:0] wd);
        for (int i = 0; i < nbytes(sz); i++) mdl[d][int'(a) + i] = wd[8*i +: 8];
    endtask

    // Issues one request on instance d starting just after an edge and returns
    // the observed response; lat counts edges from acceptance to resp_valid.
    task automatic xact(input int d, input logic [31:0] a, input logic w, input logic [1:0] sz,
                        input logic u, input logic [31:0] wd,
                        output int lat, output logic [31:0] rdat, output logic err);
        int n;
        req_addr = a; req_write = w; req_size = sz; req_unsigned = u; req_wdata = wd;
        vld[d] = 1'b1;
        n = 0;
        while (!rdy[d] && n < 100) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        vld[d] = 1'b0;
        lat = 1;
        while (!rv[d] && lat < 300) begin
            @(posedge clk); #1; lat++;
        end
        rdat = rd[d];
        err  = re[d];
        if (w && !exp_err(a, sz)) model_store(d, a, sz, wd);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rdy[d] !== 1'b1 || rv[d] !== 1'b0 || rd[d] !== 32'd0 || re[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state dut%0d: got rdy=%b rv=%b rd=%h err=%b want 1 0 0 0",
                         d, rdy[d], rv[d], rd[d], re[d]);
            end
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_word_store();
        int lat; logic [31:0] r; logic e;
        xact(0, 32'h10, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF, lat, r, e);
        checks++;
        if (lat !== 4 || e !== 1'b0 || r !== 32'd0) begin
            errors++;
            $display("FAIL word_store: got lat=%0d err=%b rd=%h want 4 0 0", lat, e, r);
        end
        xact(0, 32'h10, 1'b0, 2'b10, 1'b0, 32'h0, lat, r, e);
        checks++;
        if (lat !== 4 || e !== 1'b0 || r !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL word_load: got lat=%0d err=%b rd=%h want 4 0 deadbeef", lat, e, r);
        end
    endtask

    task automatic test_lanes();
        int lat; logic [31:0] r; logic e;
        xact(0, 32'h20, 1'b1, 2'b10, 1'b0, 32'h11223344, lat, r, e);
        xact(0, 32'h22, 1'b1, 2'b00, 1'b0, 32'h5A5A5AAA, lat, r, e);
        xact(0, 32'h20, 1'b0, 2'b10, 1'b0, 32'h0, lat, r, e);
        checks++;
        if (r !== 32'h11AA3344 || e !== 1'b0) begin
            errors++; $display("FAIL byte_store_lane: got %h want 11aa3344", r);
        end
        xact(0, 32'h22, 1'b0, 2'b00, 1'b0, 32'h0, lat, r, e);
        checks++;
        if (r !== 32'hFFFFFFAA) begin
            errors++; $display("FAIL signed_byte_load: got %h want ffffffaa", r);
        end
        xact(0, 32'h22, 1'b0, 2'b00, 1'b1, 32'h0, lat, r, e);
        checks++;
        if (r !== 32'h000000AA) begin
            errors++; $display("FAIL unsigned_byte_load: got %h want 000000aa", r);
        end
        xact(0, 32'h22, 1'b0, 2'b01, 1'b0, 32'h0, lat, r, e);
        checks++;
        if (r !== 32'h000011AA) begin
            errors++; $display("FAIL signed_half_load: got %h want 000011aa", r);
        end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] r; logic e;
        xact(0, 32'h06, 1'b0, 2'b10, 1'b0, 32'h0, lat, r, e);
        checks++;
        if (e !== 1'b1 || r !== 32'd0) begin
            errors++; $display("FAIL misaligned_word_load: got err=%b rd=%h want 1 0", e, r);
        end
        xact(0, 32'h21, 1'b1, 2'b01, 1'b0, 32'h0000BEEF, lat, r, e);
        checks++;
        if (e !== 1'b1) begin
            errors++; $display("FAIL misaligned_half_store: got err=%b want 1", e);
        end
        xact(0, 32'h20, 1'b0, 2'b10, 1'b0, 32'h0, lat, r, e);
        checks++;
        if (r !== 32'h11AA3344 || e !== 1'b0) begin
            errors++; $display("FAIL error_store_suppressed: got %h want 11aa3344", r);
        end
        xact(0, 32'(4 * DEPTH), 1'b1, 2'b10, 1'b0, 32'h12345678, lat, r, e);
        checks++;
        if (e !== 1'b1 || lat !== 4) begin
            errors++; $display("FAIL out_of_range: got err=%b lat=%0d want 1 4", e, lat);
        end
        xact(0, 32'h20, 1'b0, 2'b11, 1'b0, 32'h0, lat, r, e);
        checks++;
        if (e !== 1'b1 || r !== 32'd0) begin
            errors++; $display("FAIL illegal_size: got err=%b rd=%h want 1 0", e, r);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] r; logic e;
        logic [31:0] data [3];
        for (int k = 0; k < 3; k++) data[k] = $urandom;
        req_addr = 32'h0; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_wdata = data[0];
        vld[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rdy[1] !== 1'b1) begin
                errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, rdy[1]);
            end
            @(posedge clk); #1;
            model_store(1, req_addr, 2'b10, req_wdata);
            checks++;
            if (rv[1] !== 1'b1 || re[1] !== 1'b0) begin
                errors++; $display("FAIL b2b_resp[%0d]: got rv=%b err=%b want 1 0", k, rv[1], re[1]);
            end
            if (k < 2) begin
                req_addr  = 32'(4 * (k + 1));
                req_wdata = data[k + 1];
            end else begin
                vld[1] = 1'b0;
            end
        end
        @(posedge clk); #1;
        checks++;
        if (rv[1] !== 1'b0) begin
            errors++; $display("FAIL b2b_end: got rv=%b want 0", rv[1]);
        end
        for (int k = 0; k < 3; k++) begin
            xact(1, 32'(4 * k), 1'b0, 2'b10, 1'b0, 32'h0, lat, r, e);
            checks++;
            if (r !== data[k] || lat !== 1) begin
                errors++;
                $display("FAIL b2b_readback[%0d]: got %h lat=%0d want %h 1", k, r, lat, data[k]);
            end
        end
    endtask

    task automatic test_handshake();
        int lat; logic [31:0] r; logic e;
        xact(2, 32'h0, 1'b1, 2'b10, 1'b0, 32'h11111111, lat, r, e);
        xact(2, 32'h4, 1'b1, 2'b10, 1'b0, 32'h22222222, lat, r, e);
        req_addr = 32'h0; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        vld[2] = 1'b1;
        @(posedge clk); #1;           // request A accepted here
        req_addr = 32'h4;             // request B presented during BUSY
        checks++;
        if (rdy[2] !== 1'b0 || rv[2] !== 1'b0) begin
            errors++; $display("FAIL hs_busy1: got rdy=%b rv=%b want 0 0", rdy[2], rv[2]);
        end
        @(posedge clk); #1;
        checks++;
        if (rdy[2] !== 1'b0 || rv[2] !== 1'b0) begin
            errors++; $display("FAIL hs_busy2: got rdy=%b rv=%b want 0 0", rdy[2], rv[2]);
        end
        @(posedge clk); #1;
        checks++;
        if (rv[2] !== 1'b1 || rdy[2] !== 1'b1 || rd[2] !== 32'h11111111) begin
            errors++;
            $display("FAIL hs_resp_a: got rv=%b rdy=%b rd=%h want 1 1 11111111", rv[2], rdy[2], rd[2]);
        end
        @(posedge clk); #1;           // B accepted in RESP
        vld[2] = 1'b0;
        lat = 1;
        while (!rv[2] && lat < 300) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (lat !== 3 || rd[2] !== 32'h22222222) begin
            errors++; $display("FAIL hs_resp_b: got lat=%0d rd=%h want 3 22222222", lat, rd[2]);
        end
    endtask

    task automatic test_reset_midop();
        int lat; int n; logic [31:0] r; logic e;
        logic [31:0] want;
        req_addr = 32'h40; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_wdata = 32'hCAFEF00D;
        vld[0] = 1'b1;
        n = 0;
        while (!rdy[0] && n < 100) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;           // accepted
        vld[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++;
        if (rdy[0] !== 1'b1 || rv[0] !== 1'b0 || rd[0] !== 32'd0 || re[0] !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset_outputs: got rdy=%b rv=%b rd=%h err=%b want 1 0 0 0",
                     rdy[0], rv[0], rd[0], re[0]);
        end
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (k == 2) reset = 1'b1;
            checks++;
            if (rv[0] !== 1'b0) begin
                errors++; $display("FAIL midop_no_resp[%0d]: got rv=%b want 0", k, rv[0]);
            end
        end
        want = exp_rdata(0, 32'h40, 1'b0, 2'b10, 1'b0);
        xact(0, 32'h40, 1'b0, 2'b10, 1'b0, 32'h0, lat, r, e);
        checks++;
        if (r !== want || r !== 32'd0) begin
            errors++; $display("FAIL midop_store_dropped: got %h want 00000000", r);
        end
    endtask

    task automatic test_random();
        int lat; int d; logic [31:0] r; logic e;
        logic [31:0] a; logic w; logic [1:0] sz; logic u; logic [31:0] wd;
        logic [31:0] want_r; logic want_e;
        for (int it = 0; it < 60; it++) begin
            d  = $urandom_range(0, 2);
            a  = ($urandom_range(0, 9) == 0) ? 32'(4 * DEPTH + $urandom_range(0, 255))
                                             : 32'($urandom_range(0, 63));
            sz = 2'($urandom_range(0, 3));
            w  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            wd = $urandom;
            want_r = exp_rdata(d, a, w, sz, u);
            want_e = exp_err(a, sz);
            xact(d, a, w, sz, u, wd, lat, r, e);
            checks++;
            if (lat !== lat_of(d) || r !== want_r || e !== want_e) begin
                errors++;
                $display("FAIL random[%0d] dut%0d a=%h w=%b sz=%b u=%b: got lat=%0d rd=%h err=%b want %0d %h %b",
                         it, d, a, w, sz, u, lat, r, e, lat_of(d), want_r, want_e);
            end
            @(posedge clk); #1;
            checks++;
            if (rv[d] !== 1'b0 || rd[d] !== want_r || re[d] !== want_e) begin
                errors++;
                $display("FAIL random_hold[%0d]: got rv=%b rd=%h err=%b want 0 %h %b",
                         it, rv[d], rd[d], re[d], want_r, want_e);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int d = 0; d < 3; d++) begin
            vld[d] = 1'b0;
            for (int i = 0; i < 4 * DEPTH; i++) mdl[d][i] = 8'h00;
        end
        req_addr = 32'd0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_wdata = 32'd0;
        reset = 1'b0;
        test_reset();
        test_word_store();
        test_lanes();
        test_errors();
        test_back_to_back();
        test_handshake();
        test_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory_mc.md
# data_memory_mc

Multi-cycle, parametrised data memory for the pipelined and cache-based CPU generations. It replaces the single-cycle asynchronous-read data memory. Accesses are issued through a valid/ready request channel and complete after a programmable latency. It supports byte, halfword and word accesses, with sign/zero extension on loads and lane-masked stores. Misaligned and out-of-range accesses are reported with an error flag instead of touching the array.

## Interface
Parameters:
- MEM_DEPTH, 16384, number of 32-bit words in the array.
- LATENCY, 4, cycles from request acceptance to response; legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; while low, the block is held in reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_addr  in  32  byte address.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0; ignored for word and for stores.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- resp_error  out  1  valid with resp_valid; the access was misaligned, illegal-size or out-of-range.

## Operation
- FSM has three states:
  - IDLE: req_ready=1.
  - BUSY: req_ready=0; a down-counter runs.
  - RESP: resp_valid=1 and req_ready=1.
- Accept: req_valid && req_ready at a rising edge.
  - On accept, the block latches addr, write, size, unsigned and wdata.
  - On accept, counter <= LATENCY-1.
  - Next state is RESP if LATENCY==1, else BUSY.
- BUSY: counter decrements each cycle. When counter==1 at an edge, the next state is RESP.
- Commit edge: the edge that enters RESP.
  - A store is written to the array on this edge.
  - A load samples the array on this edge.
  - resp_rdata and resp_error are registered on this edge.
- RESP lasts exactly one cycle.
  - If a new request is accepted in RESP, the next state is BUSY (or RESP again if LATENCY==1).
  - Otherwise the next state is IDLE.
- There is no response backpressure. The requester must take the resp_valid pulse.
- Word index is req_addr[31:2]; byte lane is addr[1:0], little-endian (lane k = bits 8k+7:8k).
- Store lane masks:
  - Byte store writes only lane addr[1:0].
  - Halfword store writes lanes addr[1]*2 and addr[1]*2+1.
  - Word store writes all lanes.
  - Unselected lanes are preserved.
- Load extraction: the selected byte or half is shifted to bit 0, then sign- or zero-extended per req_unsigned.
- Error conditions; any one sets resp_error=1, suppresses the write and forces resp_rdata=0:
  - size 11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr[31:2] >= MEM_DEPTH.
- Array contents are zero at time 0 and are NOT cleared by reset. They persist across reset.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, counter=0.
- Reset asserted mid-operation: the pending request is dropped with no response. A store whose commit edge has not occurred is never written.
- Latency: a request accepted at edge T gives resp_valid high during the cycle following edge T+LATENCY-1. That is, the response is visible LATENCY cycles after the request cycle.
- Throughput: one request per LATENCY cycles when the requester issues in RESP.
- resp_rdata and resp_error hold their values after RESP until the next commit edge. resp_valid is the only qualifier.
- Read-after-write: a load committed after a store's commit edge returns the stored data. There is no same-cycle forwarding case, because only one request is outstanding.
- req_valid while req_ready=0 is ignored. The request is not latched, and the requester must hold it.

## Test plan
- Reset then word store: LATENCY=4, store addr 0x10, data 0xDEADBEEF, size 10.
  - Required: resp_valid exactly 4 cycles after the request cycle, resp_error=0.
  - Required: a following word load at 0x10 returns 0xDEADBEEF.
- Byte/half lanes: start from word 0x20 = 0x11223344.
  - Byte store 0xAA at 0x22 makes the word 0x11AA3344.
  - Signed byte load at 0x22 returns 0xFFFFFFAA; unsigned returns 0x000000AA.
  - Signed half load at 0x22 returns 0x000011AA.
- Errors:
  - Word load at 0x06 gives resp_error=1, resp_rdata=0.
  - Half store at 0x21 gives error and leaves memory unchanged.
  - Word store at addr 4*MEM_DEPTH gives error.
  - size 11 gives error.
- Back-to-back: LATENCY=1, req_valid held high for 3 requests.
  - Required: 3 consecutive resp_valid pulses, with req_ready=1 throughout.
- Handshake: LATENCY=3, req_valid asserted during BUSY with a different addr.
  - Required: that request is ignored until RESP, then accepted there.
- Reset mid-op: word store to 0x40 accepted, reset pulled low 2 cycles later with LATENCY=4.
  - Required: no resp_valid; a later load at 0x40 returns the old value 0x00000000.
  - Required: outputs are at their reset values while reset is low.
